// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with arbitrary depth, occupancy count, threshold flags,
// registered read port with valid strobe, synchronous flush and error pulses.
module sync_fifo_flags #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  // A write into a full FIFO is accepted when a read frees a slot in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_en);

  always_ff @(posedge clk) begin
    if (!flush && wr_acc)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid  <= rd_acc;
      overflow  <= wr_en & ~wr_acc;
      underflow <= rd_en & empty;
      if (wr_acc)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (rd_acc) begin
        rd_ptr  <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
